// File: rtl/video_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : video_mon_pkg
// Purpose  : Shared constants, error-bit indices, FSM state type and the
//            saturating-increment helper used by the video frame monitor.
// Revision : 1.0 - initial release
// ============================================================================
package video_mon_pkg;

  // CRC-16-CCITT: no reflection, no final XOR
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Bit positions inside the 4-bit result error field
  localparam int ERR_WIDTH  = 0;  // first-line width differs from expected
  localparam int ERR_HEIGHT = 1;  // line count differs from expected
  localparam int ERR_LINE   = 2;  // a later line differed from the first one
  localparam int ERR_DE_BND = 3;  // de was high in the boundary cycle

  localparam logic [11:0] CNT_MAX = 12'hFFF;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_CAPTURE = 1'b1
  } state_t;

  // 12-bit counter increment that sticks at its maximum
  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == CNT_MAX) ? v : v + 12'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/video_frame_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : video_frame_monitor_if
// Purpose  : Result channel of the frame monitor (valid/ready handshake plus
//            the per-frame measurement fields).
// Revision : 1.0 - initial release
// ============================================================================
interface video_frame_monitor_if;
  import video_mon_pkg::*;

  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_frame;
  logic [11:0] res_width;
  logic [11:0] res_height;
  logic [15:0] res_crc;
  logic [3:0]  res_err;
  logic        res_overrun;

  // Producer side: the monitor
  modport master (
    output res_valid, res_frame, res_width, res_height, res_crc, res_err, res_overrun,
    input  res_ready
  );

  // Consumer side
  modport slave (
    input  res_valid, res_frame, res_width, res_height, res_crc, res_err, res_overrun,
    output res_ready
  );
endinterface
`default_nettype wire

// File: rtl/video_mon_crc.sv
`default_nettype none
// ============================================================================
// Module   : video_mon_crc
// Purpose  : Combinational CRC-16-CCITT update absorbing one W-bit word per
//            call, most significant bit first.
// Revision : 1.0 - initial release
// ============================================================================
module video_mon_crc
  import video_mon_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [15:0]  crc_in,
  input  logic [W-1:0] data,
  output logic [15:0]  crc_out
);

  logic [15:0] c;
  logic        fb;

  // Unrolled bit-serial LFSR: one shift per data bit, MSB first
  always_comb begin
    c  = crc_in;
    fb = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end
    crc_out = c;
  end

endmodule
`default_nettype wire

// File: rtl/video_frame_monitor.sv
`default_nettype none
// ============================================================================
// Module   : video_frame_monitor
// Purpose  : Measures active width/height, line consistency and pixel CRC of
//            each video frame and reports them over a valid/ready channel.
// Revision : 1.0 - initial release
// ============================================================================
module video_frame_monitor
  import video_mon_pkg::*;
#(
  parameter int RW     = 5,
  parameter int GW     = 6,
  parameter int BW     = 5,
  parameter int H_EXP  = 640,
  parameter int V_EXP  = 480,
  parameter int VS_NEG = 1
) (
  input  logic          pclk,
  input  logic          reset_n,
  input  logic          vsync,
  input  logic          hsync,
  input  logic          de,
  input  logic [RW-1:0] red,
  input  logic [GW-1:0] green,
  input  logic [BW-1:0] blue,
  video_frame_monitor_if.master res
);

  localparam int          PW      = RW + GW + BW;
  localparam logic [11:0] H_EXP_W = 12'(H_EXP);
  localparam logic [11:0] V_EXP_W = 12'(V_EXP);
  // Delayed vsync starts at the inactive level so release never looks like an edge
  localparam logic        VS_IDLE = (VS_NEG != 0) ? 1'b1 : 1'b0;

  state_t      state, state_nxt;
  logic        vs_d, de_d;
  logic [11:0] line_cnt, height, width;
  logic        err_line;
  logic [15:0] crc, crc_nxt;
  logic [15:0] frame;

  logic        boundary, capture, pix, line_end, load;
  logic [11:0] height_nxt, width_nxt;
  logic        err_line_nxt;
  logic [3:0]  err_vec;

  // hsync carries no measurement information
  logic        unused_hsync;
  assign unused_hsync = hsync;

  video_mon_crc #(.W(PW)) u_crc (
    .crc_in  (crc),
    .data    ({red, green, blue}),
    .crc_out (crc_nxt)
  );

  // Boundary detect, pixel/line qualifiers and the closing-frame view
  always_comb begin
    boundary     = (VS_NEG != 0) ? (vs_d & ~vsync) : (~vs_d & vsync);
    capture      = (state == ST_CAPTURE);
    pix          = capture & de & ~boundary;
    line_end     = capture & de_d & ~de;
    load         = capture & boundary;
    height_nxt   = line_end ? sat_inc(height) : height;
    width_nxt    = (line_end && height == 12'd0) ? line_cnt : width;
    err_line_nxt = err_line | (line_end && height != 12'd0 && line_cnt != width);
    err_vec             = 4'b0000;
    err_vec[ERR_WIDTH]  = (width_nxt != H_EXP_W);
    err_vec[ERR_HEIGHT] = (height_nxt != V_EXP_W);
    err_vec[ERR_LINE]   = err_line_nxt;
    err_vec[ERR_DE_BND] = de & boundary;
  end

  // FSM state register
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // FSM next state: the first boundary arms capture, later ones keep it
  always_comb begin
    state_nxt = state;
    if (state == ST_IDLE && boundary) state_nxt = ST_CAPTURE;
  end

  // Per-frame measurement counters, CRC and frame numbering
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      vs_d     <= VS_IDLE;
      de_d     <= 1'b0;
      line_cnt <= 12'd0;
      height   <= 12'd0;
      width    <= 12'd0;
      err_line <= 1'b0;
      crc      <= CRC_INIT;
      frame    <= 16'd0;
    end else begin
      vs_d <= vsync;
      // A line open at the boundary is dropped, so its de fall must not end a line
      de_d <= boundary ? 1'b0 : de;
      if (boundary) begin
        line_cnt <= 12'd0;
        height   <= 12'd0;
        width    <= 12'd0;
        err_line <= 1'b0;
        crc      <= CRC_INIT;
      end else begin
        if (line_end)  line_cnt <= 12'd0;
        else if (pix)  line_cnt <= sat_inc(line_cnt);
        height   <= height_nxt;
        width    <= width_nxt;
        err_line <= err_line_nxt;
        if (pix) crc <= crc_nxt;
      end
      if (load) frame <= frame + 16'd1;
    end
  end

  // Result register with valid/ready handshake and overrun flag
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      res.res_valid   <= 1'b0;
      res.res_overrun <= 1'b0;
      res.res_frame   <= 16'd0;
      res.res_width   <= 12'd0;
      res.res_height  <= 12'd0;
      res.res_crc     <= CRC_INIT;
      res.res_err     <= 4'b0000;
    end else if (load) begin
      res.res_valid   <= 1'b1;
      res.res_overrun <= res.res_valid & ~res.res_ready;
      res.res_frame   <= frame;
      res.res_width   <= width_nxt;
      res.res_height  <= height_nxt;
      res.res_crc     <= crc;
      res.res_err     <= err_vec;
    end else if (res.res_valid && res.res_ready) begin
      res.res_valid   <= 1'b0;
      res.res_overrun <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_video_frame_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_frame_monitor
// Purpose  : Directed self-checking bench for video_frame_monitor (4x3 frames).
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_frame_monitor;

  logic       pclk    = 1'b0;
  logic       reset_n = 1'b0;
  logic       vsync   = 1'b1;
  logic       hsync   = 1'b1;
  logic       de      = 1'b0;
  logic [4:0] red     = '0;
  logic [5:0] green   = '0;
  logic [4:0] blue    = '0;

  video_frame_monitor_if rif ();

  video_frame_monitor #(
    .RW(5), .GW(6), .BW(5), .H_EXP(4), .V_EXP(3), .VS_NEG(1)
  ) dut (
    .pclk    (pclk),
    .reset_n (reset_n),
    .vsync   (vsync),
    .hsync   (hsync),
    .de      (de),
    .red     (red),
    .green   (green),
    .blue    (blue),
    .res     (rif)
  );

  always #5 pclk = ~pclk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] m_crc = 16'hFFFF;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [15:0] w);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      fb = r[15] ^ w[i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic send_line(input int n);
    logic [15:0] w;
    for (int i = 0; i < n; i++) begin
      w = 16'($urandom);
      {red, green, blue} = w;
      de = 1'b1;
      m_crc = crc_step(m_crc, w);
      tick();
    end
    de = 1'b0;
    hsync = 1'b0;
    tick();
    hsync = 1'b1;
    tick();
  endtask

  task automatic send_frame(input int l0, input int l1, input int l2);
    send_line(l0);
    send_line(l1);
    send_line(l2);
  endtask

  // vsync falling edge cycle; optional de pixel and ready in that same cycle
  task automatic boundary(input logic de_at, input logic rdy_at);
    vsync = 1'b0;
    de    = de_at;
    if (de_at) {red, green, blue} = 16'hBEEF;
    rif.res_ready = rdy_at;
    tick();
    vsync = 1'b1;
    de    = 1'b0;
    rif.res_ready = 1'b0;
    tick();
  endtask

  task automatic check_res(input string tag, input logic [15:0] f, input logic [11:0] w,
                           input logic [11:0] h, input logic [15:0] c,
                           input logic [3:0] e, input logic ov);
    check({tag, ".valid"},   32'(rif.res_valid),   32'd1);
    check({tag, ".frame"},   32'(rif.res_frame),   32'(f));
    check({tag, ".width"},   32'(rif.res_width),   32'(w));
    check({tag, ".height"},  32'(rif.res_height),  32'(h));
    check({tag, ".crc"},     32'(rif.res_crc),     32'(c));
    check({tag, ".err"},     32'(rif.res_err),     32'(e));
    check({tag, ".overrun"}, 32'(rif.res_overrun), 32'(ov));
  endtask

  task automatic handshake(input string tag);
    rif.res_ready = 1'b1;
    tick();
    rif.res_ready = 1'b0;
    check({tag, ".valid_drop"}, 32'(rif.res_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] exp_crc;
    rif.res_ready = 1'b0;

    // Reset values
    tick();
    tick();
    check("rst.valid",   32'(rif.res_valid),   32'd0);
    check("rst.overrun", 32'(rif.res_overrun), 32'd0);
    check("rst.frame",   32'(rif.res_frame),   32'd0);
    check("rst.width",   32'(rif.res_width),   32'd0);
    check("rst.height",  32'(rif.res_height),  32'd0);
    check("rst.err",     32'(rif.res_err),     32'd0);
    check("rst.crc",     32'(rif.res_crc),     32'hFFFF);
    reset_n = 1'b1;
    tick();
    check("post_rst.valid", 32'(rif.res_valid), 32'd0);

    // Pixels before the first boundary are ignored; first boundary gives no result
    send_line(4);
    boundary(1'b0, 1'b0);
    check("arm.valid", 32'(rif.res_valid), 32'd0);

    // Two normal 4x3 frames
    m_crc = 16'hFFFF;
    send_frame(4, 4, 4);
    exp_crc = m_crc;
    boundary(1'b0, 1'b0);
    m_crc = 16'hFFFF;
    check_res("f0", 16'd0, 12'd4, 12'd3, exp_crc, 4'b0000, 1'b0);
    handshake("f0");
    send_frame(4, 4, 4);
    exp_crc = m_crc;
    boundary(1'b0, 1'b0);
    m_crc = 16'hFFFF;
    check_res("f1", 16'd1, 12'd4, 12'd3, exp_crc, 4'b0000, 1'b0);
    handshake("f1");

    // Frame with no active pixels
    boundary(1'b0, 1'b0);
    check_res("empty", 16'd2, 12'd0, 12'd0, 16'hFFFF, 4'b0011, 1'b0);
    handshake("empty");

    // Inconsistent line widths 4,4,5
    send_frame(4, 4, 5);
    exp_crc = m_crc;
    boundary(1'b0, 1'b0);
    m_crc = 16'hFFFF;
    check_res("ragged", 16'd3, 12'd4, 12'd3, exp_crc, 4'b0100, 1'b0);
    handshake("ragged");

    // Overrun: two results without ready, then ready coincident with a third load
    send_frame(4, 4, 4);
    exp_crc = m_crc;
    boundary(1'b0, 1'b0);
    m_crc = 16'hFFFF;
    check_res("ov_a", 16'd4, 12'd4, 12'd3, exp_crc, 4'b0000, 1'b0);
    boundary(1'b0, 1'b0);
    check_res("ov_b", 16'd5, 12'd0, 12'd0, 16'hFFFF, 4'b0011, 1'b1);
    send_frame(4, 4, 4);
    exp_crc = m_crc;
    boundary(1'b0, 1'b1);
    m_crc = 16'hFFFF;
    check_res("ov_c", 16'd6, 12'd4, 12'd3, exp_crc, 4'b0000, 1'b0);
    handshake("ov_c");

    // de high in the boundary cycle: flagged, excluded from this and the next frame
    send_frame(4, 4, 4);
    exp_crc = m_crc;
    boundary(1'b1, 1'b0);
    m_crc = 16'hFFFF;
    check_res("de_bnd", 16'd7, 12'd4, 12'd3, exp_crc, 4'b1000, 1'b0);
    handshake("de_bnd");
    send_frame(4, 4, 4);
    exp_crc = m_crc;
    boundary(1'b0, 1'b0);
    m_crc = 16'hFFFF;
    check_res("after_bnd", 16'd8, 12'd4, 12'd3, exp_crc, 4'b0000, 1'b0);
    handshake("after_bnd");

    // Reset mid-frame: partial frame discarded, numbering restarts at 0
    send_line(4);
    send_line(4);
    reset_n = 1'b0;
    #2;
    check("mid_rst.frame", 32'(rif.res_frame), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    send_line(4);
    boundary(1'b0, 1'b0);
    check("mid_rst.arm_valid", 32'(rif.res_valid), 32'd0);
    m_crc = 16'hFFFF;
    send_frame(4, 4, 4);
    exp_crc = m_crc;
    boundary(1'b0, 1'b0);
    check_res("mid_rst", 16'd0, 12'd4, 12'd3, exp_crc, 4'b0000, 1'b0);
    handshake("mid_rst");
    tick();
    check("mid_rst.single", 32'(rif.res_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/video_frame_monitor.md
VIDEO_FRAME_MONITOR -- requirements
Module: video_frame_monitor

Interface
REQ-001 Parameter RW, default 5, red component width.
REQ-002 Parameter GW, default 6, green component width.
REQ-003 Parameter BW, default 5, blue component width.
REQ-004 Parameter H_EXP, default 640, expected active pixels per line.
REQ-005 Parameter V_EXP, default 480, expected active lines per frame.
REQ-006 Parameter VS_NEG, default 1: 1 means the frame boundary is the vsync falling edge; 0 means the rising edge.
REQ-007 Port pclk, input, 1, pixel clock; every flop samples on its rising edge.
REQ-008 Port reset_n, input, 1, asynchronous active-low reset.
REQ-009 Port vsync / hsync / de, input, 1 each, video timing; de marks an active pixel.
REQ-010 Port red / green / blue, input, RW / GW / BW, pixel data, sampled only when de=1.
REQ-011 Port res_valid, output, 1, result available.
REQ-012 Port res_ready, input, 1, consumer accepts the result.
REQ-013 Port res_frame, output, 16, frame sequence number.
REQ-014 Port res_width, output, 12, active pixels in the first line of the frame.
REQ-015 Port res_height, output, 12, active lines in the frame.
REQ-016 Port res_crc, output, 16, CRC over the frame's pixels.
REQ-017 Port res_err, output, 4: [0] width differs from H_EXP; [1] height differs from V_EXP; [2] line widths inconsistent; [3] de high in a boundary cycle.
REQ-018 Port res_overrun, output, 1, an unaccepted earlier result was overwritten.

Function
REQ-019 The boundary cycle SHALL be the first cycle in which vsync differs from its one-cycle-delayed copy in the direction selected by VS_NEG.
REQ-020 The FSM SHALL have two states. IDLE (entered on reset) ignores pixels and moves to CAPTURE on the first boundary. CAPTURE SHALL stay in CAPTURE on every later boundary and close the current frame.
REQ-021 In CAPTURE, each de=1 cycle SHALL increment the line pixel counter, saturating at 4095.
REQ-022 A line SHALL end on a de 1->0 transition. At line end, height SHALL increment (saturating at 4095).
REQ-023 The first line's count SHALL be stored as the width. Each later line's count SHALL be compared with the stored width, and any mismatch SHALL set sticky err[2].
REQ-024 The CRC SHALL be CRC-16-CCITT (poly 0x1021, init 0xFFFF, no reflection, no final XOR). It SHALL process one word {red,green,blue} per de=1 cycle, MSB first.
REQ-025 At a boundary in CAPTURE, the finished frame's width, height, CRC, err[0..3] and frame number SHALL be loaded into the result register. res_valid SHALL be 1 on the following cycle.
REQ-026 On that same boundary, all counters, the CRC and the sticky errors SHALL restart for the new frame, and the frame number SHALL increment, wrapping 0xFFFF->0x0000. The first reported frame SHALL be 0.
REQ-027 A de=1 pixel in a boundary cycle SHALL be excluded from all counts and the CRC, and SHALL set err[3] of the frame being closed.
REQ-028 A line still open (de=1) at a boundary SHALL be discarded, not counted.
REQ-029 Result fields SHALL hold stable while res_valid=1 and res_ready=0.
REQ-030 A handshake occurs when res_valid=1 and res_ready=1. On a handshake with no new result, res_valid SHALL fall on the next cycle.
REQ-031 If a new result loads while res_valid=1 and no handshake occurs that cycle, the new result SHALL overwrite the old one and res_overrun SHALL be 1 with it.
REQ-032 If a handshake and a new load happen in the same cycle, res_valid SHALL stay 1, the new result SHALL appear, and res_overrun SHALL be 0.
REQ-033 hsync SHALL be ignored for measurement and exists for timing reference only.

Reset
REQ-034 While reset_n=0, the FSM SHALL be in IDLE.
REQ-035 While reset_n=0, res_valid, res_overrun, res_frame, res_width, res_height and res_err SHALL be 0, and res_crc SHALL be 0xFFFF.
REQ-036 While reset_n=0, the delayed vsync SHALL equal the inactive level, so that no boundary is detected on the first cycle after release.
REQ-037 Reset asserted mid-frame SHALL discard the partial frame without producing a result.

Structure
REQ-038 Package video_mon_pkg SHALL hold the CRC polynomial and init constants, the err bit indices, and the FSM state enum.
REQ-039 Sub-module video_mon_crc SHALL implement the parallel one-word-per-cycle CRC update, parametrised by word width RW+GW+BW.

Verification
REQ-040 Stimulus: two frames of 4x3 pixels with H_EXP=4 and V_EXP=3. Required response: second boundary gives res_width=4, res_height=3, res_err=0, res_frame=0, and res_crc matching the bench model.
REQ-041 Stimulus: a frame with zero de cycles. Required response: res_width=0, res_height=0, res_crc=0xFFFF, res_err=4'b0011.
REQ-042 Stimulus: line widths 4,4,5. Required response: res_width=4, res_err[2]=1.
REQ-043 Stimulus: res_ready held 0 across two boundaries. Required response: the second result replaces the first with res_overrun=1. Then ready pulsed coincident with a third load: res_valid stays 1 and res_overrun=0.
REQ-044 Stimulus: de=1 during the boundary cycle. Required response: err[3]=1 and that pixel absent from the counts and the CRC.
REQ-045 Stimulus: reset_n pulsed low mid-frame, then two boundaries. Required response: exactly one result, with res_frame=0.
